// File: rtl/axi_rd_arbiter.sv
// Arbitrates the single AXI read master between the IFU fetch port and the MMU load port.
// One outstanding single-beat read at a time; responses return as registered 1-cycle pulses.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic [31:0]       if_rdata,
  output logic              if_rvalid,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_size,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic              rd_err,
  output logic              busy,
  output logic [3:0]        ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic [2:0]        ARPORT,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [3:0]        RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
);

  localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
  localparam logic [3:0]  ID_IF    = 4'd0;
  localparam logic [3:0]  ID_LD    = 4'd1;
  localparam logic [2:0]  PORT_IF  = 3'b100;
  localparam logic [2:0]  PORT_LD  = 3'b000;
  localparam logic [2:0]  SIZE_IF  = 3'b010;

  typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R} state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic                kill_flag;
  logic                owner_ld;

  logic if_want, streak_full, grant_if, grant_ld, r_done, resp_err, if_drop;

  // Grant decision and response qualifiers; a kill in IDLE masks the fetch request.
  always_comb begin
    if_want     = if_req & ~if_kill;
    streak_full = (streak == STREAK_W'(MAX_STREAK));
    grant_if    = if_want & (~ld_req | streak_full);
    grant_ld    = ld_req & ~grant_if;
    r_done      = RVALID & RLAST;
    resp_err    = (RRESP != 2'b00) | (RID != ARID);
    if_drop     = kill_flag | if_kill;
  end

  assign ARLEN   = 8'd0;
  assign ARBURST = 2'b01;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      ARADDR    <= '0;
      ARID      <= '0;
      ARSIZE    <= '0;
      ARPORT    <= '0;
      owner_ld  <= 1'b0;
      streak    <= '0;
      kill_flag <= 1'b0;
      if_rvalid <= 1'b0;
      ld_rvalid <= 1'b0;
      rd_err    <= 1'b0;
      if_rdata  <= '0;
      ld_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ld_rvalid <= 1'b0;
      rd_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          kill_flag <= 1'b0;
          if (grant_if) begin
            owner_ld <= 1'b0;
            ARID     <= ID_IF;
            ARPORT   <= PORT_IF;
            ARSIZE   <= SIZE_IF;
            ARADDR   <= if_addr;
            streak   <= '0;
          end else if (grant_ld) begin
            owner_ld <= 1'b1;
            ARID     <= ID_LD;
            ARPORT   <= PORT_LD;
            ARSIZE   <= ld_size;
            ARADDR   <= ld_addr;
            // Count loads only while a fetch is actually waiting.
            if (!if_want)
              streak <= '0;
            else if (!streak_full)
              streak <= streak + STREAK_W'(1);
          end
          if (grant_if | grant_ld) begin
            ARVALID <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_AR;
          end
        end
        ST_AR: begin
          if (!owner_ld && if_kill) kill_flag <= 1'b1;
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= ST_R;
          end
        end
        ST_R: begin
          if (!owner_ld && if_kill) kill_flag <= 1'b1;
          if (r_done) begin
            RREADY    <= 1'b0;
            busy      <= 1'b0;
            kill_flag <= 1'b0;
            state     <= ST_IDLE;
            if (owner_ld) begin
              ld_rvalid <= 1'b1;
              ld_rdata  <= RDATA;
              rd_err    <= resp_err;
            end else if (!if_drop) begin
              if_rvalid <= 1'b1;
              if_rdata  <= RDATA[31:0];
              rd_err    <= resp_err;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_axi_rd_arbiter;

  localparam int unsigned AW   = 64;
  localparam int unsigned DW   = 64;
  localparam int unsigned MAXS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, if_req, if_kill, ld_req;
  logic [AW-1:0] if_addr, ld_addr;
  logic [2:0]    ld_size;
  logic [31:0]   if_rdata;
  logic [DW-1:0] ld_rdata;
  logic          if_rvalid, ld_rvalid, rd_err, busy;
  logic [3:0]    ARID, RID;
  logic [AW-1:0] ARADDR;
  logic [7:0]    ARLEN;
  logic [2:0]    ARSIZE, ARPORT;
  logic [1:0]    ARBURST, RRESP;
  logic          ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0] RDATA;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
    .rd_err(rd_err), .busy(busy),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARPORT(ARPORT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the one outstanding transaction, tracked as
  // none (0) / address offered (1) / waiting for the beat (2).
  bit          m_ready = 1'b0;
  int          m_phase = 0;
  int          m_streak = 0;
  bit          m_ld, m_killed;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  bit          e_if_v, e_ld_v, e_err;
  logic [31:0] e_if_d;
  logic [63:0] e_ld_d;

  initial forever begin : model
    bit fetch_ok;
    @(posedge clk);
    if (rst) begin
      m_ready = 1'b1; m_phase = 0; m_streak = 0;
      e_if_v = 1'b0; e_ld_v = 1'b0; e_err = 1'b0;
    end else if (m_ready) begin
      e_if_v = 1'b0; e_ld_v = 1'b0; e_err = 1'b0;
      if (m_phase == 0) begin
        fetch_ok = if_req && !if_kill;
        if (fetch_ok && (!ld_req || m_streak == MAXS)) begin
          m_ld = 1'b0; m_addr = if_addr; m_size = 3'd2; m_streak = 0;
          m_phase = 1; m_killed = 1'b0;
        end else if (ld_req) begin
          m_ld = 1'b1; m_addr = ld_addr; m_size = ld_size;
          m_streak = fetch_ok ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
          m_phase = 1; m_killed = 1'b0;
        end
      end else if (m_phase == 1) begin
        if (!m_ld && if_kill) m_killed = 1'b1;
        if (ARREADY) m_phase = 2;
      end else begin
        if (RVALID && RLAST) begin
          m_phase = 0;
          if (m_ld) begin
            e_ld_v = 1'b1; e_ld_d = RDATA;
            e_err = (RRESP != 2'b00) || (RID != 4'd1);
          end else if (!(m_killed || if_kill)) begin
            e_if_v = 1'b1; e_if_d = RDATA[31:0];
            e_err = (RRESP != 2'b00) || (RID != 4'd0);
          end
        end else if (!m_ld && if_kill) begin
          m_killed = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model; also logs DUT grant order.
  bit prev_arv = 1'b0;
  bit dut_glog[$];

  initial forever begin : compare
    @(negedge clk);
    if (m_ready) begin
      chk("ARVALID", 64'(ARVALID), 64'(m_phase == 1));
      chk("RREADY", 64'(RREADY), 64'(m_phase == 2));
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("if_rvalid", 64'(if_rvalid), 64'(e_if_v));
      chk("ld_rvalid", 64'(ld_rvalid), 64'(e_ld_v));
      chk("rd_err", 64'(rd_err), 64'(e_err));
      chk("rvalid_excl", 64'(if_rvalid & ld_rvalid), 64'd0);
      if (m_phase == 1) begin
        chk("ARID", 64'(ARID), 64'(m_ld));
        chk("ARADDR", ARADDR, m_addr);
        chk("ARSIZE", 64'(ARSIZE), 64'(m_size));
        chk("ARPORT", 64'(ARPORT), m_ld ? 64'd0 : 64'd4);
        chk("ARLEN", 64'(ARLEN), 64'd0);
        chk("ARBURST", 64'(ARBURST), 64'd1);
      end
      if (e_if_v) chk("if_rdata", 64'(if_rdata), 64'(e_if_d));
      if (e_ld_v) chk("ld_rdata", ld_rdata, e_ld_d);
      if (ARVALID && !prev_arv) dut_glog.push_back(ARID[0]);
    end
    prev_arv = ARVALID;
  end

  // AXI slave: drives AR ready and a single-beat R response from the model's view.
  int          slv_ar_pct = 100;
  int          slv_rdelay = 0;
  int          slv_rresp  = 0;
  bit          slv_bad_id = 1'b0;
  bit          slv_fix_en = 1'b0;
  logic [63:0] slv_fix    = '0;

  initial begin : slave
    int r_wait = 0;
    int prev_ph = 0;
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RID = '0; RDATA = '0; RRESP = '0;
    forever begin
      @(negedge clk);
      #1;
      ARREADY = ($urandom_range(99) < slv_ar_pct);
      if (m_phase == 2) begin
        if (prev_ph != 2) r_wait = (slv_rdelay < 0) ? $urandom_range(4) : slv_rdelay;
        if (r_wait > 0) begin
          RVALID = 1'b0; RLAST = 1'b0; r_wait--;
        end else begin
          RVALID = 1'b1; RLAST = 1'b1;
          RDATA  = slv_fix_en ? slv_fix : {$urandom, $urandom};
          RID    = (slv_bad_id && $urandom_range(9) == 0) ? 4'($urandom_range(15, 2))
                                                         : (m_ld ? 4'd1 : 4'd0);
          RRESP  = (slv_rresp >= 0) ? 2'(slv_rresp)
                                    : (($urandom_range(5) == 0) ? 2'($urandom_range(3, 1)) : 2'd0);
        end
      end else begin
        RVALID = 1'b0; RLAST = 1'b0;
      end
      prev_ph = m_phase;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int ph, input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      ok = (m_phase == ph);
    end
    chk("wait_phase", 64'(ok), 64'd1);
  endtask

  task automatic t_fetch_only();
    slv_fix_en = 1'b1; slv_fix = 64'hDEAD_BEEF_0010_0073;
    if_addr = 64'h8000_0000; if_req = 1'b1;
    @(negedge clk);
    chk("t1_arvalid", 64'(ARVALID), 64'd1);
    chk("t1_arid", 64'(ARID), 64'd0);
    chk("t1_arport", 64'(ARPORT), 64'd4);
    chk("t1_arsize", 64'(ARSIZE), 64'd2);
    chk("t1_araddr", ARADDR, 64'h8000_0000);
    @(negedge clk);
    chk("t1_rready", 64'(RREADY), 64'd1);
    @(negedge clk);
    chk("t1_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("t1_if_rdata", 64'(if_rdata), 64'h0010_0073);
    chk("t1_rd_err", 64'(rd_err), 64'd0);
    if_req = 1'b0; slv_fix_en = 1'b0;
    idle(3);
  endtask

  task automatic t_both();
    if_addr = 64'h8000_0100; if_req = 1'b1;
    ld_addr = 64'h8000_1000; ld_size = 3'd3; ld_req = 1'b1;
    @(negedge clk);
    chk("t2_ld_arid", 64'(ARID), 64'd1);
    chk("t2_ld_arsize", 64'(ARSIZE), 64'd3);
    chk("t2_ld_araddr", ARADDR, 64'h8000_1000);
    idle(2);
    chk("t2_ld_rvalid", 64'(ld_rvalid), 64'd1);
    chk("t2_if_quiet", 64'(if_rvalid), 64'd0);
    ld_req = 1'b0;
    @(negedge clk);
    chk("t2_if_arvalid", 64'(ARVALID), 64'd1);
    chk("t2_if_arid", 64'(ARID), 64'd0);
    chk("t2_if_araddr", ARADDR, 64'h8000_0100);
    idle(2);
    chk("t2_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("t2_ld_quiet", 64'(ld_rvalid), 64'd0);
    if_req = 1'b0;
    idle(3);
  endtask

  task automatic t_streak();
    bit exp_order [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dut_glog.delete();
    ld_addr = 64'h8000_4000; ld_size = 3'd0; ld_req = 1'b1;
    if_addr = 64'h8000_0400; if_req = 1'b1;
    for (int i = 0; i < 120 && dut_glog.size() < 10; i++) @(negedge clk);
    ld_req = 1'b0; if_req = 1'b0;
    chk("t3_grant_count", 64'(dut_glog.size() >= 10), 64'd1);
    for (int i = 0; i < 10 && i < dut_glog.size(); i++)
      chk($sformatf("t3_grant%0d", i), 64'(dut_glog[i]), 64'(exp_order[i]));
    idle(5);
  endtask

  task automatic t_kill();
    int cnt = 0;
    bit done = 1'b0;
    if_addr = 64'h8000_0200; if_req = 1'b1; slv_rdelay = 5;
    wait_phase(2, 10);
    if_kill = 1'b1; if_req = 1'b0;
    @(negedge clk);
    if_kill = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (if_rvalid) cnt++;
      if (!busy) done = 1'b1;
    end
    chk("t4_no_if_rvalid", 64'(cnt), 64'd0);
    chk("t4_completed", 64'(done), 64'd1);
    slv_rdelay = 0; if_addr = 64'h8000_0300; if_req = 1'b1;
    @(negedge clk);
    chk("t4_new_arvalid", 64'(ARVALID), 64'd1);
    chk("t4_new_araddr", ARADDR, 64'h8000_0300);
    idle(2);
    chk("t4_new_if_rvalid", 64'(if_rvalid), 64'd1);
    if_req = 1'b0;
    idle(3);
  endtask

  task automatic t_ar_stall();
    bit got = 1'b0;
    logic err_seen = 1'b0;
    ld_addr = 64'h8000_2000; ld_size = 3'd1; ld_req = 1'b1;
    slv_ar_pct = 0; slv_rresp = 2;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("t5_arvalid", 64'(ARVALID), 64'd1);
      chk("t5_araddr", ARADDR, 64'h8000_2000);
      chk("t5_arid", 64'(ARID), 64'd1);
      if (i < 3) @(negedge clk);
    end
    slv_ar_pct = 100;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = ld_rvalid;
      err_seen = rd_err;
    end
    chk("t5_ld_rvalid", 64'(got), 64'd1);
    chk("t5_rd_err", 64'(err_seen), 64'd1);
    ld_req = 1'b0; slv_rresp = 0;
    idle(3);
  endtask

  task automatic t_reset_in_r();
    ld_addr = 64'h8000_3000; ld_size = 3'd2; ld_req = 1'b1; slv_rdelay = 3;
    wait_phase(2, 10);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_arvalid", 64'(ARVALID), 64'd0);
    chk("t6_rready", 64'(RREADY), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_ld_rvalid", 64'(ld_rvalid), 64'd0);
    rst = 1'b0; ld_req = 1'b0; slv_rdelay = 0;
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_resp", 64'(ld_rvalid | if_rvalid), 64'd0);
    end
  endtask

  task automatic t_random(input int cycles);
    slv_ar_pct = 70; slv_rdelay = -1; slv_rresp = -1; slv_bad_id = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rst = ($urandom_range(499) == 0);
      if (if_kill) begin
        if_kill = 1'b0; if_req = 1'b0;
      end else if (if_req && (e_if_v || $urandom_range(59) == 0)) begin
        if_req = 1'b0;
      end else if (if_req && $urandom_range(24) == 0) begin
        if_kill = 1'b1;
      end else if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1'b1; if_addr = {$urandom, $urandom} & ~64'h3;
      end
      if (ld_req && (e_ld_v || $urandom_range(79) == 0)) begin
        ld_req = 1'b0;
      end else if (!ld_req && $urandom_range(2) == 0) begin
        ld_req = 1'b1; ld_addr = {$urandom, $urandom}; ld_size = 3'($urandom_range(3));
      end
    end
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; if_kill = 1'b0; ld_req = 1'b0;
    slv_ar_pct = 100; slv_rdelay = 0;
    idle(20);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_kill = 1'b0; ld_req = 1'b0;
    if_addr = '0; ld_addr = '0; ld_size = '0;
    idle(2);
    chk("rst_arvalid", 64'(ARVALID), 64'd0);
    chk("rst_rready", 64'(RREADY), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_araddr", ARADDR, 64'd0);
    chk("rst_arid", 64'(ARID), 64'd0);
    chk("rst_arsize", 64'(ARSIZE), 64'd0);
    chk("rst_pulses", 64'({if_rvalid, ld_rvalid, rd_err}), 64'd0);
    rst = 1'b0;
    t_fetch_only();
    t_both();
    t_streak();
    t_kill();
    t_ar_stall();
    t_reset_in_r();
    t_random(4000);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
